// File: rtl/timer_write_seq_pkg.sv
// Shared constants for the RTC timer setpoint path: field address codes, BCD limits
// and the write-sequencer state encoding (also used by the capture/alarm logic).
package timer_write_seq_pkg;

    localparam logic [7:0] FIELD_HOUR = 8'h43;
    localparam logic [7:0] FIELD_MIN  = 8'h42;
    localparam logic [7:0] FIELD_SEC  = 8'h41;
    localparam logic [7:0] FIELD_IDLE = 8'h00;

    localparam logic [7:0] BCD_MAX_HOUR   = 8'h23;
    localparam logic [7:0] BCD_MAX_MINSEC = 8'h59;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CHECK  = 4'd1;
    localparam logic [3:0] ST_WR_H   = 4'd2;
    localparam logic [3:0] ST_WAIT_H = 4'd3;
    localparam logic [3:0] ST_WR_M   = 4'd4;
    localparam logic [3:0] ST_WAIT_M = 4'd5;
    localparam logic [3:0] ST_WR_S   = 4'd6;
    localparam logic [3:0] ST_WAIT_S = 4'd7;
    localparam logic [3:0] ST_FIN    = 4'd8;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } setpointT;

endpackage

// File: rtl/timer_write_seq_if.sv
// Request / RTC-bus signal bundle between the setpoint source and the write sequencer.
interface timer_write_seq_if;

    logic       start;
    logic [7:0] hour_in;
    logic [7:0] min_in;
    logic [7:0] seg_in;
    logic       bus_done;
    logic [7:0] en_sav_swr;
    logic [7:0] dataWr;
    logic       wr_req;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, hour_in, min_in, seg_in, bus_done,
        input  en_sav_swr, dataWr, wr_req, busy, done, err
    );

    modport slave (
        input  start, hour_in, min_in, seg_in, bus_done,
        output en_sav_swr, dataWr, wr_req, busy, done, err
    );

endinterface

// File: rtl/bcd_range_check.sv
// Accepts a byte only if both nibbles are decimal digits and the value does not exceed max.
module bcd_range_check (
    input  logic [7:0] value,
    input  logic [7:0] max,
    output logic       valid
);

    // Once both nibbles are 0-9, plain binary compare orders BCD values correctly.
    assign valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);

endmodule

// File: rtl/timer_write_seq.sv
// Writes a validated hour/min/sec setpoint to the RTC as three acknowledged bus writes,
// with a per-field acknowledge timeout.
module timer_write_seq
    import timer_write_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    timer_write_seq_if.slave  bus
);

    localparam logic [9:0] WAIT_LIMIT = 10'(TIMEOUT_CYCLES - 1);

    logic [3:0] stateQ;
    logic [3:0] stateNext;
    setpointT   snapQ;
    logic [9:0] waitCnt;
    logic       timeoutErrQ;

    logic hourOk;
    logic minOk;
    logic secOk;
    logic snapValid;
    logic isWr;
    logic isWait;
    logic atLimit;

    bcd_range_check hourChk (.value(snapQ.hour), .max(BCD_MAX_HOUR),   .valid(hourOk));
    bcd_range_check minChk  (.value(snapQ.min),  .max(BCD_MAX_MINSEC), .valid(minOk));
    bcd_range_check secChk  (.value(snapQ.sec),  .max(BCD_MAX_MINSEC), .valid(secOk));

    assign snapValid = hourOk && minOk && secOk;
    assign isWr      = (stateQ == ST_WR_H)   || (stateQ == ST_WR_M)   || (stateQ == ST_WR_S);
    assign isWait    = (stateQ == ST_WAIT_H) || (stateQ == ST_WAIT_M) || (stateQ == ST_WAIT_S);
    assign atLimit   = (waitCnt == WAIT_LIMIT);

    always_comb begin
        // NOTE: default first so every path assigns stateNext; otherwise a latch is inferred.
        stateNext = stateQ;
        case (stateQ)
            ST_IDLE:   if (bus.start) stateNext = ST_CHECK;
            ST_CHECK:  stateNext = snapValid ? ST_WR_H : ST_IDLE;
            ST_WR_H:   stateNext = ST_WAIT_H;
            ST_WAIT_H: if (bus.bus_done) stateNext = ST_WR_M; else if (atLimit) stateNext = ST_IDLE;
            ST_WR_M:   stateNext = ST_WAIT_M;
            ST_WAIT_M: if (bus.bus_done) stateNext = ST_WR_S; else if (atLimit) stateNext = ST_IDLE;
            ST_WR_S:   stateNext = ST_WAIT_S;
            ST_WAIT_S: if (bus.bus_done) stateNext = ST_FIN;  else if (atLimit) stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the snapshot is reset along with control state, so a reset leaves no stale setpoint.
        if (reset) begin
            stateQ      <= ST_IDLE;
            snapQ       <= '0;
            waitCnt     <= '0;
            timeoutErrQ <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            stateQ      <= stateNext;
            timeoutErrQ <= isWait && !bus.bus_done && atLimit;
            if (stateQ == ST_IDLE && bus.start) begin
                snapQ <= {bus.hour_in, bus.min_in, bus.seg_in};
            end
            // Clearing in WR_x means the counter reads 0 in the first WAIT_x cycle.
            if (isWr) begin
                waitCnt <= '0;
            end else if (isWait) begin
                waitCnt <= waitCnt + 10'd1;
            end
        end
    end

    logic [7:0] fieldCode;
    logic [7:0] fieldData;

    always_comb begin
        fieldCode = FIELD_IDLE;
        fieldData = 8'h00;
        case (stateQ)
            ST_WR_H, ST_WAIT_H: begin fieldCode = FIELD_HOUR; fieldData = snapQ.hour; end
            ST_WR_M, ST_WAIT_M: begin fieldCode = FIELD_MIN;  fieldData = snapQ.min;  end
            ST_WR_S, ST_WAIT_S: begin fieldCode = FIELD_SEC;  fieldData = snapQ.sec;  end
            default: ;
        endcase
    end

    // Timeout err shows in the IDLE cycle after the last wait; check err shows in CHECK.
    assign bus.en_sav_swr = fieldCode;
    assign bus.dataWr     = fieldData;
    assign bus.wr_req     = isWr;
    assign bus.busy       = (stateQ != ST_IDLE);
    assign bus.done       = (stateQ == ST_FIN);
    assign bus.err        = ((stateQ == ST_CHECK) && !snapValid) || timeoutErrQ;

endmodule
